// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-requester arbiter/sequencer in front of Data_Memory. Port 0 is the
//   core load/store unit, port 1 the debug/loader port. Each accepted request
//   becomes exactly one memory access. Completion is a one-cycle gnt pulse.
//   Reads also return registered read data with rvalid.
//
// Ports
//   clk, reset                 clock, async active-low reset
//   rN_req/we/addr/wdata       request from port N (held until rN_gnt)
//   rN_gnt/rvalid/rdata        completion pulse, read-valid, read data
//   Mem_Addr/Write_Data        registered address/data to Data_Memory
//   MemWrite/MemRead           registered memory strobes
//   Read_Data                  combinational read data from Data_Memory
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | strobes low; sample requests, latch the winner's request
// ACCESS | one-cycle memory access; write commits / read captured at end
// DONE   | one-cycle gnt (and rvalid for reads) to the winner; reqs ignored
module data_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] Read_Data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q;
  logic                ptr_q;
  logic                win_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                mem_we_q;
  logic                mem_re_q;
  logic                r0_gnt_q;
  logic                r0_rvalid_q;
  logic [DATA_W-1:0]   r0_rdata_q;
  logic                r1_gnt_q;
  logic                r1_rvalid_q;
  logic [DATA_W-1:0]   r1_rdata_q;

  logic                any_req;
  logic                win_d;
  logic                we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;

  // Port 1 wins when it is the sole requester, or when both request and the
  // pointer favours it.
  always_comb begin
    any_req = r0_req | r1_req;
    win_d   = r1_req & (~r0_req | ptr_q);
    we_d    = win_d ? r1_we    : r0_we;
    addr_d  = win_d ? r1_addr  : r0_addr;
    wdata_d = win_d ? r1_wdata : r0_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      r0_gnt_q    <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_gnt_q    <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r1_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            // Strobes are registered so they are valid for the whole ACCESS cycle.
            mem_we_q <= we_d;
            mem_re_q <= ~we_d;
            state_q  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
          if (!we_q) begin
            if (win_q) r1_rdata_q <= Read_Data;
            else       r0_rdata_q <= Read_Data;
          end
          r0_gnt_q    <= ~win_q;
          r0_rvalid_q <= ~win_q & ~we_q;
          r1_gnt_q    <= win_q;
          r1_rvalid_q <= win_q & ~we_q;
          ptr_q       <= ~win_q;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          r0_gnt_q    <= 1'b0;
          r0_rvalid_q <= 1'b0;
          r1_gnt_q    <= 1'b0;
          r1_rvalid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Mem_Addr   = addr_q;
  assign Write_Data = wdata_q;
  assign MemWrite   = mem_we_q;
  assign MemRead    = mem_re_q;
  assign r0_gnt     = r0_gnt_q;
  assign r0_rvalid  = r0_rvalid_q;
  assign r0_rdata   = r0_rdata_q;
  assign r1_gnt     = r1_gnt_q;
  assign r1_rvalid  = r1_rvalid_q;
  assign r1_rdata   = r1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [63:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [63:0] r0_rdata, r1_rdata;
  logic [63:0] Mem_Addr, Write_Data, Read_Data;
  logic        MemWrite, MemRead;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .MemWrite(MemWrite),
    .MemRead(MemRead), .Read_Data(Read_Data)
  );

  // Memory model: 16 words; unwritten words read as 0x1000 + word index.
  logic [63:0] mem [0:15];
  logic [15:0] wr_vld = '0;
  logic [3:0]  widx;
  assign widx = Mem_Addr[5:2];
  assign Read_Data = wr_vld[widx] ? mem[widx] : (64'h1000 + {60'd0, widx});
  always @(posedge clk) begin
    if (MemWrite) begin
      mem[widx]    <= Write_Data;
      wr_vld[widx] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r0_req, r0_we;
    logic [63:0] r0_addr, r0_wdata;
    logic        r1_req, r1_we;
    logic [63:0] r1_addr;
    logic        e_r0g, e_r0v, e_r1g, e_r1v, e_mw, e_mr;
    logic [63:0] e_addr, e_wd, e_r0rd, e_r1rd;
  } vec_t;

  function automatic vec_t mk(
    input logic a_req, input logic a_we, input logic [63:0] a_addr, input logic [63:0] a_wd,
    input logic b_req, input logic b_we, input logic [63:0] b_addr,
    input logic g0, input logic v0, input logic g1, input logic v1,
    input logic mw, input logic mr, input logic [63:0] ea, input logic [63:0] ewd,
    input logic [63:0] rd0, input logic [63:0] rd1);
    vec_t v;
    v.r0_req = a_req; v.r0_we = a_we; v.r0_addr = a_addr; v.r0_wdata = a_wd;
    v.r1_req = b_req; v.r1_we = b_we; v.r1_addr = b_addr;
    v.e_r0g = g0; v.e_r0v = v0; v.e_r1g = g1; v.e_r1v = v1;
    v.e_mw = mw; v.e_mr = mr; v.e_addr = ea; v.e_wd = ewd;
    v.e_r0rd = rd0; v.e_r1rd = rd1;
    return v;
  endfunction

  vec_t vecs [13];
  int   gq [$];
  int   g0c, g1c, ngnt, nrd;

  initial begin
    // Expected outputs are those seen after the edge that samples each row's inputs.
    vecs[0]  = mk(0,0,0,0,          0,0,0,  0,0,0,0, 0,0, 0, 0, 0, 0);
    vecs[1]  = mk(1,1,4,64'hBE2EA,  0,0,0,  0,0,0,0, 1,0, 4, 64'hBE2EA, 0, 0);
    vecs[2]  = mk(1,0,64'h3c,0,     0,0,0,  1,0,0,0, 0,0, 4, 0, 0, 0);
    vecs[3]  = mk(0,0,0,0,          0,0,0,  0,0,0,0, 0,0, 4, 0, 0, 0);
    vecs[4]  = mk(0,0,0,0,          1,0,4,  0,0,0,0, 0,1, 4, 0, 0, 0);
    vecs[5]  = mk(0,0,0,0,          1,0,4,  0,0,1,1, 0,0, 4, 0, 0, 64'hBE2EA);
    vecs[6]  = mk(0,0,0,0,          0,0,0,  0,0,0,0, 0,0, 4, 0, 0, 64'hBE2EA);
    vecs[7]  = mk(1,0,8,0,          1,0,12, 0,0,0,0, 0,1, 8, 0, 0, 64'hBE2EA);
    vecs[8]  = mk(1,0,8,0,          1,0,12, 1,1,0,0, 0,0, 8, 0, 64'h1002, 64'hBE2EA);
    vecs[9]  = mk(0,0,0,0,          1,0,12, 0,0,0,0, 0,0, 8, 0, 64'h1002, 64'hBE2EA);
    vecs[10] = mk(0,0,0,0,          1,0,12, 0,0,0,0, 0,1, 12, 0, 64'h1002, 64'hBE2EA);
    vecs[11] = mk(0,0,0,0,          1,0,12, 0,0,1,1, 0,0, 12, 0, 64'h1002, 64'h1003);
    vecs[12] = mk(0,0,0,0,          0,0,0,  0,0,0,0, 0,0, 12, 0, 64'h1002, 64'h1003);

    // Reset with random inputs: every output must be zero.
    for (int c = 0; c < 2; c++) begin
      r0_req = 1'($urandom); r0_we = 1'($urandom);
      r0_addr = {$urandom, $urandom}; r0_wdata = {$urandom, $urandom};
      r1_req = 1'($urandom); r1_we = 1'($urandom);
      r1_addr = {$urandom, $urandom}; r1_wdata = {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
      chk($sformatf("rst%0d_gnt_rvalid", c), {60'd0, r0_gnt, r0_rvalid, r1_gnt, r1_rvalid}, 0);
      chk($sformatf("rst%0d_strobes", c), {62'd0, MemWrite, MemRead}, 0);
      chk($sformatf("rst%0d_mem_addr", c), Mem_Addr, 0);
      chk($sformatf("rst%0d_write_data", c), Write_Data, 0);
      chk($sformatf("rst%0d_rdata", c), r0_rdata | r1_rdata, 0);
    end
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    reset = 1'b1;

    // Table: idle, write, read-back, contention.
    for (int i = 0; i < 13; i++) begin
      r0_req = vecs[i].r0_req; r0_we = vecs[i].r0_we;
      r0_addr = vecs[i].r0_addr; r0_wdata = vecs[i].r0_wdata;
      r1_req = vecs[i].r1_req; r1_we = vecs[i].r1_we;
      r1_addr = vecs[i].r1_addr; r1_wdata = 0;
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d_r0_gnt", i), r0_gnt, vecs[i].e_r0g);
      chk($sformatf("v%0d_r0_rvalid", i), r0_rvalid, vecs[i].e_r0v);
      chk($sformatf("v%0d_r1_gnt", i), r1_gnt, vecs[i].e_r1g);
      chk($sformatf("v%0d_r1_rvalid", i), r1_rvalid, vecs[i].e_r1v);
      chk($sformatf("v%0d_MemWrite", i), MemWrite, vecs[i].e_mw);
      chk($sformatf("v%0d_MemRead", i), MemRead, vecs[i].e_mr);
      chk($sformatf("v%0d_Mem_Addr", i), Mem_Addr, vecs[i].e_addr);
      if (vecs[i].e_mw) chk($sformatf("v%0d_Write_Data", i), Write_Data, vecs[i].e_wd);
      chk($sformatf("v%0d_r0_rdata", i), r0_rdata, vecs[i].e_r0rd);
      chk($sformatf("v%0d_r1_rdata", i), r1_rdata, vecs[i].e_r1rd);
    end

    // Both ports held for 12 cycles: grant order must be 0,1,0,1.
    r0_req = 1; r0_we = 0; r0_addr = 8;
    r1_req = 1; r1_we = 0; r1_addr = 12;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (r0_gnt && r1_gnt) chk($sformatf("rr_cycle%0d_both_gnt", c), 1, 0);
      if (r0_gnt) gq.push_back(0);
      if (r1_gnt) gq.push_back(1);
    end
    r0_req = 0; r1_req = 0;
    chk("rr_grant_count", gq.size(), 4);
    if (gq.size() == 4) begin
      chk("rr_order", {gq[0][7:0], gq[1][7:0], gq[2][7:0], gq[3][7:0]}, 32'h00010001);
    end

    // Reset during ACCESS of a write: strobe drops at once, no gnt, no commit.
    r0_req = 1; r0_we = 1; r0_addr = 8; r0_wdata = 64'h55;
    @(posedge clk); @(negedge clk);
    chk("rstw_access_MemWrite", MemWrite, 1);
    chk("rstw_access_addr", Mem_Addr, 8);
    #2 reset = 1'b0;
    #1;
    chk("rstw_MemWrite_drop", MemWrite, 0);
    chk("rstw_MemRead_drop", MemRead, 0);
    r0_req = 0; r0_we = 0;
    @(posedge clk); @(negedge clk);
    chk("rstw_no_gnt", {62'd0, r0_gnt, r1_gnt}, 0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    r1_req = 1; r1_we = 0; r1_addr = 8;
    g0c = -1;
    for (int c = 1; c <= 10 && g0c < 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (r1_gnt) g0c = c;
    end
    r1_req = 0;
    chk("rstw_read_gnt_latency", g0c, 2);
    chk("rstw_read_old_data", r1_rdata, 64'h1002);
    chk("rstw_r0_rdata", r0_rdata, 0);
    @(posedge clk); @(negedge clk);

    // Held request: second identical access, gnt again 3 cycles later.
    r1_req = 1; r1_we = 0; r1_addr = 12;
    g0c = -1; g1c = -1; ngnt = 0; nrd = 0;
    for (int c = 1; c <= 12 && g1c < 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (MemRead) begin
        nrd++;
        chk($sformatf("held_c%0d_addr", c), Mem_Addr, 12);
      end
      if (r1_gnt) begin
        ngnt++;
        if (g0c < 0) g0c = c; else g1c = c;
      end
    end
    chk("held_first_gnt", g0c, 2);
    chk("held_gnt_spacing", g1c - g0c, 3);
    chk("held_read_count", nrd, 2);
    // Reset during DONE: gnt and rvalid drop immediately.
    if (g1c >= 0) begin
      #1 reset = 1'b0;
      #1;
      chk("rstd_gnt_drop", {62'd0, r1_gnt, r1_rvalid}, 0);
    end else begin
      chk("held_second_gnt_timeout", 0, 1);
    end
    r1_req = 0;
    @(posedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-requester arbiter and sequencer in front of Data_Memory. Port 0 is the core load/store unit; port 1 is the debug/loader port. Each accepted request becomes exactly one memory access: a read or a write. Completion is signalled with a one-cycle grant pulse and, for reads, registered read data.

Parameters:
ADDR_W, 64, width of requester and memory addresses
DATA_W, 64, width of write and read data

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
r0_req  input  1  port-0 request; held high until r0_gnt is seen
r0_we  input  1  port-0 op: 1=write, 0=read
r0_addr  input  ADDR_W  port-0 address
r0_wdata  input  DATA_W  port-0 write data
r0_gnt  output  1  port-0 completion pulse (one cycle)
r0_rvalid  output  1  port-0 read data valid (with r0_gnt, reads only)
r0_rdata  output  DATA_W  port-0 registered read data
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as port 0, for port 1
Mem_Addr  output  ADDR_W  to Data_Memory
Write_Data  output  DATA_W  to Data_Memory
MemWrite  output  1  to Data_Memory; memory writes on the rising edge while high
MemRead  output  1  to Data_Memory
Read_Data  input  DATA_W  from Data_Memory; combinational, valid in the same cycle as MemRead

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: gnt, rvalid, rdata, Mem_Addr, Write_Data, MemWrite, MemRead.
  - Priority pointer selects port 0.
- FSM has three states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - MemWrite=0, MemRead=0; Mem_Addr and Write_Data hold their last values.
  - On a clock edge with any req=1, pick a winner:
    - If only one port requests, it wins.
    - If both request, the pointer's port wins.
  - Latch the winner's id, we, addr and wdata into internal registers; go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (exactly one cycle):
  - Mem_Addr, Write_Data and MemWrite are driven from the latched registers; MemRead = ~latched we.
  - The memory write commits on the edge that ends ACCESS.
  - For a read, Read_Data is captured on that same edge into the winner's rdata register.
  - The other port's rdata is untouched.
- DONE (one cycle):
  - MemWrite=0, MemRead=0.
  - Winner's gnt=1; rvalid=1 only if the operation was a read.
  - Pointer moves to the non-winning port.
  - Go to IDLE unconditionally.
  - req inputs are ignored in DONE.
- Latency: from the IDLE edge that samples req to gnt high is 2 cycles. Throughput is one access per 3 cycles.
- Requester rules:
  - Requester fields may change after the sampling edge; the latched copy is used.
  - The requester must drop req on the edge ending its gnt cycle.
  - req still high in the following IDLE is a new request.
- rdata registers hold their value until the next read by the same port. Writes never alter rdata.
- Round-robin: with both ports requesting continuously, grants alternate 0,1,0,1. Neither port can be starved beyond one transaction.
- Reset asserted during ACCESS:
  - MemWrite and MemRead drop immediately, so no write commits.
  - No gnt is issued and the transaction is lost; requesters re-request after reset.
- Reset asserted during DONE: gnt and rvalid drop immediately.
- No combinational path from req to any output; all outputs are registered.

Test Plan:
- Reset check: reset=0 for 2 cycles with random inputs -> every output is 0. After release with no req, the block stays idle: MemRead=MemWrite=0.
- Single write: r0 write, addr=4, wdata=0xBE2EA -> one cycle with MemWrite=1, Mem_Addr=4, Write_Data=0xBE2EA. Next cycle r0_gnt=1, r0_rvalid=0.
- Read-back: then r1 read, addr=4 -> MemRead=1 for one cycle. Next cycle r1_gnt=1, r1_rvalid=1, r1_rdata=0xBE2EA. r0_rdata is unchanged.
- Contention: both ports request reads (addr 8 and 12) in the same cycle after reset -> r0 is served first, r1 is granted 3 cycles later. Both held continuously -> grant order 0,1,0,1 over 12 cycles.
- Reset mid-write: r0 write, addr=8, data=0x55; pull reset low during ACCESS before the clock edge -> MemWrite falls immediately and no gnt. A later read of addr 8 returns the prior contents.
- Held request: r1 keeps req=1 after its gnt -> a second identical access starts from the following IDLE, with gnt again 3 cycles later.
